uart_tx_fifo: RTL and testbench

Buffered 8N1 UART transmitter that produces the SoC's `UART_TXD` serial line, the signal the bench's 4x-oversampling receiver decodes and prints. A CPU-side byte-write port feeds a small FIFO. An internal baud divider and a frame state machine shift bytes out LSB-first, so short strings go out without the core polling per byte. It sits in `MF8A18_SoC` between the peripheral write decode and the top-level `UART_TXD` pin.

---
 rtl/uart_tx_fifo.sv | 170 +++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: byte-write port -> FIFO (or holding register) -> LSB-first serial line.
// Define UART_TX_FIFO_EN for a 2^FIFO_AW deep FIFO; otherwise a single holding register is used.
module uart_tx_fifo #(
  parameter int CLK_HZ  = 50000000,
  parameter int BAUD    = 115200,
  parameter int FIFO_AW = 3
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       ready,
  output logic       busy,
  output logic       txd
);
  localparam int DIV = CLK_HZ / BAUD;
  localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [2:0]    bit_idx, bit_nx;
  logic [7:0]    shift, shift_nx;
  logic          txd_nx, busy_nx, ready_nx;
  logic          push, pop, has_data, fill_nx;
  logic [7:0]    head;

  assign push = wr_en && ready;

`ifdef UART_TX_FIFO_EN
  localparam int DEPTH = 1 << FIFO_AW;

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wp, rp;
  logic [FIFO_AW:0]   count, count_nx;

  assign has_data = (count != '0);
  assign head     = mem[rp];

  always_comb begin
    count_nx = count;
    case ({push, pop})
      2'b10:   count_nx = count + 1'b1;
      2'b01:   count_nx = count - 1'b1;
      default: count_nx = count;
    endcase
  end

  assign fill_nx  = (count_nx != '0);
  assign ready_nx = (count_nx < (FIFO_AW + 1)'(DEPTH));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      count <= count_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wp] <= wr_data;
  end
`else
  logic [7:0] hold;
  logic       hold_v, hold_v_nx;

  assign has_data  = hold_v;
  assign head      = hold;
  assign hold_v_nx = (hold_v && !pop) || push;
  assign fill_nx   = hold_v_nx;
  assign ready_nx  = !hold_v_nx;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) hold_v <= 1'b0;
    else         hold_v <= hold_v_nx;
  end

  always_ff @(posedge clk) begin
    if (push) hold <= wr_data;
  end
`endif

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    bit_nx   = bit_idx;
    shift_nx = shift;
    pop      = 1'b0;
    case (state)
      IDLE: begin
        if (has_data) begin
          pop      = 1'b1;
          shift_nx = head;
          cnt_nx   = '0;
          state_nx = START;
        end
      end
      START: begin
        if (cnt == LAST) begin
          cnt_nx   = '0;
          bit_nx   = 3'd0;
          state_nx = DATA;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      DATA: begin
        if (cnt == LAST) begin
          cnt_nx   = '0;
          shift_nx = shift >> 1;
          bit_nx   = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_nx = STOP;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      STOP: begin
        if (cnt == LAST) begin
          cnt_nx = '0;
          // Pop directly from the stop bit so consecutive frames have no idle gap.
          if (has_data) begin
            pop      = 1'b1;
            shift_nx = head;
            state_nx = START;
          end else begin
            state_nx = IDLE;
          end
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase

    case (state_nx)
      START:   txd_nx = 1'b0;
      DATA:    txd_nx = shift_nx[0];
      default: txd_nx = 1'b1;
    endcase
    busy_nx = (state_nx != IDLE) || fill_nx;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= 3'd0;
      txd     <= 1'b1;
      ready   <= 1'b1;
      busy    <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      bit_idx <= bit_nx;
      txd     <= txd_nx;
      ready   <= ready_nx;
      busy    <= busy_nx;
    end
  end

  always_ff @(posedge clk) begin
    shift <= shift_nx;
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomized self-checking bench for uart_tx_fifo against a frame-level line model.
// Honours UART_TX_FIFO_EN the same way the design does.
module tb_uart_tx_fifo;
  localparam int CLK_HZ  = 700;
  localparam int BAUD    = 100;
  localparam int FIFO_AW = 3;
  localparam int DIV     = CLK_HZ / BAUD;
  localparam int FRAME   = 10 * DIV;
`ifdef UART_TX_FIFO_EN
  localparam int DEPTH = 1 << FIFO_AW;
`else
  localparam int DEPTH = 1;
`endif

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       ready, busy, txd;

  int checks = 0;
  int passed = 0;
  int dut_acc = 0;

  uart_tx_fifo #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .FIFO_AW(FIFO_AW)) dut (
    .clk(clk), .resetn(resetn), .wr_en(wr_en), .wr_data(wr_data),
    .ready(ready), .busy(busy), .txd(txd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs === exp) passed++;
    else $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
  endtask

  // Model: queue of pending bytes plus clocks remaining in the frame on the line.
  logic [7:0] q[$];
  int         rem = 0;
  logic [7:0] cur = 8'h00;
  logic       m_ready = 1'b1;

  function automatic logic exp_txd();
    int b;
    if (rem == 0) return 1'b1;
    b = (FRAME - rem) / DIV;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return cur[b-1];
  endfunction

  task automatic model_reset();
    q.delete();
    rem = 0;
    m_ready = 1'b1;
  endtask

  task automatic model_edge(input logic we, input logic [7:0] d);
    logic acc;
    acc = we && m_ready;
    if (rem > 0) rem--;
    if (rem == 0 && q.size() > 0) begin
      cur = q.pop_front();
      rem = FRAME;
    end
    if (acc) q.push_back(d);
    m_ready = (q.size() < DEPTH);
  endtask

  // Called at a falling edge; drives, advances one clock, checks, returns at the next falling edge.
  task automatic cycle(input logic we, input logic [7:0] d);
    wr_en = we;
    wr_data = d;
    if (we && ready) dut_acc++;
    @(posedge clk);
    model_edge(we, d);
    #1;
    chk("txd", {31'd0, txd}, {31'd0, exp_txd()});
    chk("ready", {31'd0, ready}, {31'd0, m_ready});
    chk("busy", {31'd0, busy}, {31'd0, (rem != 0) || (q.size() != 0)});
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'($urandom));
  endtask

  task automatic reset_check(input string tag);
    chk({tag, "_txd"}, {31'd0, txd}, 32'd1);
    chk({tag, "_ready"}, {31'd0, ready}, 32'd1);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int acc0;
    int burst;
    @(negedge clk);
    #1;
    reset_check("por");
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    model_reset();

    idle(10000);

    cycle(1'b1, 8'h55);
    idle(FRAME + 5);

    cycle(1'b1, 8'h48);
    cycle(1'b1, 8'h69);
    idle(2 * FRAME + 5);

    acc0 = dut_acc;
    for (int i = 0; i < 10; i++) cycle(1'b1, 8'(8'h30 + i));
    chk("accepted_30_39", dut_acc - acc0, (DEPTH + 1 < 10) ? DEPTH + 1 : 10);
    idle(9 * FRAME + 5);

    cycle(1'b1, 8'h0F);
    idle(4 * DIV + 3);
    #2;
    resetn = 1'b0;
    #1;
    reset_check("rst_async");
    model_reset();
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      reset_check("rst_hold");
    end
    resetn = 1'b1;
    idle(2 * FRAME);

    acc0 = dut_acc;
    cycle(1'b1, 8'hA5);
    cycle(1'b1, 8'h5A);
    chk("accepted_a5_5a", dut_acc - acc0, (DEPTH > 1) ? 2 : 1);
    idle(3 * FRAME);

    for (int i = 0; i < 3000; i++) begin
      burst = $urandom_range(0, 7);
      cycle((burst < 2) || ((i % 400) < 12), 8'($urandom));
    end
    idle((DEPTH + 2) * FRAME);
    reset_check("drained");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
